fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side engine for the 32-bit synchronous FIFO (`fifo_sync`). It pops words from the FIFO using the FIFO's `ren`/`empty`/`data_out` interface and presents them downstream as a valid/ready stream. Throughput is one word per clock, with no loss or duplication under arbitrary backpressure. It sits between the FIFO's read port and any stream consumer, replacing ad-hoc `ren` pulsing.

## Interface
Parameters:
- `DW`, 32, data width; must match the FIFO width.
- `CW`, 16, width of the popped-word counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  allow new FIFO reads while high.
- `f_empty`  in  1  FIFO empty flag.
- `f_data`  in  DW  FIFO `data_out`.
- `f_ren`  out  1  FIFO read enable.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DW  output word.
- `m_ready`  in  1  consumer accepts word.
- `busy`  out  1  words in flight or buffered.
- `pop_cnt`  out  CW  count of completed output handshakes; wraps.

## Operation
FIFO read contract (decided, shared with `fifo_sync`):
- `f_data` updates at the edge that samples `f_ren && !f_empty`.
- `f_data` is valid for the whole following cycle and holds otherwise.
- The reader never asserts `f_ren` while `f_empty` is high.

Internal state:
- 2-entry output buffer with `occ` in 0..2.
- 1-bit `inflight`: a read was issued last cycle.
- 2-state control FSM: `RUN`, `DRAIN`.

Read issue:
- Define `pop = m_valid && m_ready`.
- `f_ren = !rst && en && !f_empty && (occ + inflight - pop <= 1)`.
- `f_ren` is combinational from these terms; the only combinational path from `m_ready` is to `f_ren`.

Capture and output:
- If `inflight`, `f_data` is written into the buffer tail at the next edge.
- `m_valid = (occ != 0)`. `m_data` is the buffer head (registered).
- On `pop`, the head is removed. Capture and pop in the same cycle leave `occ` unchanged.
- Order is strictly FIFO order.

FSM:
- `RUN`: normal issue.
- `RUN -> DRAIN` when `en` = 0. In `DRAIN` no `f_ren` is issued; in-flight and buffered words are still delivered.
- `DRAIN -> RUN` when `en` = 1.

Status:
- `busy = inflight || occ != 0`.
- `pop_cnt` increments by 1 per `pop`, modulo 2^CW.

Boundary cases:
- FIFO empty: no `f_ren`; the stream runs dry cleanly, with `m_valid` low once the buffer is empty.
- Buffer full (`occ = 2`, no pop): `f_ren` held low. Buffer overflow is impossible by construction.
- `m_data` is stable while `m_valid && !m_ready`.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO entry already popped is lost; this is accepted.

## Timing
Reset values (edge with `rst` = 1):
- `occ` = 0, `inflight` = 0, FSM = `RUN`.
- `m_valid` = 0, `m_data` = 0, `busy` = 0, `pop_cnt` = 0.
- `f_ren` = 0 combinationally while `rst` is high.

Latency and throughput:
- Latency: `f_ren` high in cycle N gives `m_valid` high in cycle N+2 (N+1: FIFO output; edge N+2: buffer capture).
- Sustained throughput: 1 word/cycle with `m_ready` = 1 and the FIFO non-empty.
- Backpressure: after `m_ready` drops, at most one further `f_ren` issues (to fill buffer entry 2). `f_ren` resumes the same cycle `m_ready` returns.

## Structure
Shared package/header `fifo_pkg`:
- `DW` default 32.
- `BUF_DEPTH` = 2.
- FSM state encodings (`RUN` = 0, `DRAIN` = 1).
- Also used by `fifo_sync`.

Sub-module `fifo_skid_buf`:
- 2-entry register buffer with push/pop and `occ` output.
- The top level holds the FSM, issue logic, `inflight` and `pop_cnt`.

## Test plan
- **Reset:** `rst` high 2 cycles with FIFO non-empty and `en` = 1 -> `f_ren` = 0 throughout; all outputs 0 at the first cycle after release.
- **Streaming:** FIFO preloaded with 1..8, `en` = 1, `m_ready` = 1 -> `f_ren` high 8 consecutive cycles; `m_valid` high 8 consecutive cycles starting 2 cycles after the first `f_ren`; `m_data` = 1..8 in order; final `pop_cnt` = 8; no `f_ren` after `f_empty`.
- **Backpressure:** 8 words with `m_ready` pattern 1,0,0,1,0,1,1,0... -> the 8 words are delivered exactly once, in order; `occ + inflight` ≤ 2 always; `m_data` stable during stalls.
- **Underflow:** `f_empty` = 1 for 20 cycles -> `f_ren` = 0, `m_valid` = 0, `busy` = 0.
- **Disable mid-stream:** drop `en` after the 3rd `f_ren` with `m_ready` = 1 -> exactly 3 words (1,2,3) delivered; then `busy` = 0 and no further `f_ren`. Raising `en` resumes with word 4.
- **Reset mid-operation:** `m_ready` = 0 with `occ` = 2, then pulse `rst` 1 cycle -> next cycle `m_valid` = 0, `busy` = 0, `pop_cnt` = 0. After release, reading resumes from the FIFO's next word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its stream reader.
package fifo_pkg;

  localparam int DW        = 32;
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // A read may issue only while at most this many words would remain committed.
  localparam logic [OCC_W:0] ISSUE_LIMIT = (OCC_W + 1)'(BUF_DEPTH - 1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } rd_state_e;

  // Words that will occupy the buffer after this edge if no new read issues.
  function automatic logic [OCC_W:0] committed(input logic [OCC_W-1:0] occ,
                                               input logic             inflight,
                                               input logic             pop);
    return {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small register buffer between FIFO read data and the output stream; entry 0 is the head.
module fifo_skid_buf #(
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [fifo_pkg::OCC_W-1:0] occ
);
  import fifo_pkg::*;

  logic [DW-1:0]    mem_reg  [BUF_DEPTH];
  logic [DW-1:0]    mem_next [BUF_DEPTH];
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;
  logic             pop_ok;
  logic             push_ok;
  logic [IDX_W-1:0] wr_idx;

  assign pop_ok  = pop && (occ_reg != '0);
  assign push_ok = push && ((occ_reg != OCC_W'(BUF_DEPTH)) || pop_ok);
  // After a pop the entries shift down, so the tail slot moves with it.
  assign wr_idx  = IDX_W'(occ_reg - OCC_W'(pop_ok));
  assign occ_next = occ_reg + OCC_W'(push_ok) - OCC_W'(pop_ok);

  always_comb begin
    mem_next = mem_reg;
    if (pop_ok) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        mem_next[i] = mem_reg[i + 1];
      end
    end
    if (push_ok) begin
      mem_next[wr_idx] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      occ_reg <= occ_next;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_reg[i] <= mem_next[i];
      end
    end
  end

  assign head = mem_reg[0];
  assign occ  = occ_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from fifo_sync and presents them as a valid/ready stream at one word per clock.
module fifo_stream_reader #(
  parameter int DW = fifo_pkg::DW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          f_empty,
  input  logic [DW-1:0] f_data,
  output logic          f_ren,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          busy,
  output logic [CW-1:0] pop_cnt
);
  import fifo_pkg::*;

  rd_state_e        state_reg;
  rd_state_e        state_next;
  logic             inflight_reg;
  logic [CW-1:0]    pop_cnt_reg;
  logic [OCC_W-1:0] occ;
  logic             pop;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if (en)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Counting the word already in flight keeps the buffer from ever overflowing,
  // while crediting this cycle's pop lets reads continue at full rate.
  assign f_ren = !rst && (state_next == RUN) && !f_empty
                 && (committed(occ, inflight_reg, pop) <= ISSUE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      inflight_reg <= 1'b0;
      pop_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= f_ren;
      if (pop) begin
        pop_cnt_reg <= pop_cnt_reg + 1'b1;
      end
    end
  end

  fifo_skid_buf #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (f_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign busy    = inflight_reg || m_valid;
  assign pop_cnt = pop_cnt_reg;

endmodule
